// File: rtl/valid_sample_src_if.sv
// Sample stream between the ramp source and its consumer.
// A beat transfers on a rising edge when out_valid and out_ready are both 1. Once raised, out_valid stays up
// and out_data stays constant until that transfer happens. out_ready may change freely and never depends on out_valid.
interface valid_sample_src_if #(
  parameter int DW = 16
);
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (output out_valid, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/valid_sample_src.sv
// Turns periodic sample strobes into a ramp of test samples, buffers them in a small FIFO,
// and counts accepted and dropped strobes until a run of NSAMP samples has drained.
module valid_sample_src #(
  parameter int            DW    = 16,
  parameter int            DEPTH = 4,
  parameter logic [DW-1:0] SEED  = '0,
  parameter logic [DW-1:0] STEP  = DW'(1),
  parameter int            NSAMP = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  valid_sample_src_if.master   stream,
  output logic                 full,
  output logic [15:0]          samp_cnt,
  output logic [15:0]          drop_cnt,
  output logic                 done,
  output logic [1:0]           state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam bit          COUNTED = (NSAMP != 0);
  localparam logic [15:0] NSAMP_M1 = (NSAMP == 0) ? 16'd0 : 16'(NSAMP - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [DW-1:0] ramp;
  logic [DW-1:0] last_q;
  logic          pop;
  logic          wr_req;
  logic          push;

  assign pop    = stream.out_valid & stream.out_ready;
  assign wr_req = (state == S_RUN) & in_valid;
  // A full FIFO still takes the strobe when the head leaves in the same cycle.
  assign push   = wr_req & ((count != DEPTH_C) | pop);

  assign stream.out_valid = (count != '0);
  assign stream.out_data  = stream.out_valid ? mem[rd_ptr] : last_q;
  assign full             = (count == DEPTH_C);
  assign done             = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ramp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ramp     <= SEED;
      last_q   <= '0;
      samp_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        ramp   <= ramp + STEP;
        if (samp_cnt != 16'hFFFF) begin
          samp_cnt <= samp_cnt + 16'd1;
        end
      end
      if (wr_req && !push && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

      case (state)
        S_IDLE: begin
          if (en) begin
            state    <= S_RUN;
            samp_cnt <= '0;
            drop_cnt <= '0;
            ramp     <= SEED;
          end
        end
        S_RUN: begin
          if (!en || (COUNTED && push && (samp_cnt == NSAMP_M1))) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (count == '0) begin
            state <= S_DONE;
          end
        end
        default: begin
          if (!en) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_valid_sample_src.sv
// Directed bench for valid_sample_src: three instances cover the counted run, the long run
// (back-pressure, reset, enable drop) and the narrow wrapping ramp, all sharing one stimulus.
module tb_valid_sample_src;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  logic ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  logic        full_a, done_a, full_b, done_b, full_c, done_c;
  logic [15:0] samp_a, drop_a, samp_b, drop_b, samp_c, drop_c;
  logic [1:0]  state_a, state_b, state_c;

  valid_sample_src_if #(.DW(16)) a_if ();
  valid_sample_src_if #(.DW(16)) b_if ();
  valid_sample_src_if #(.DW(8))  c_if ();
  assign a_if.out_ready = ready;
  assign b_if.out_ready = ready;
  assign c_if.out_ready = ready;

  valid_sample_src #(.DW(16), .DEPTH(4), .SEED(16'h0), .STEP(16'h1), .NSAMP(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .stream(a_if),
    .full(full_a), .samp_cnt(samp_a), .drop_cnt(drop_a), .done(done_a), .state(state_a)
  );
  valid_sample_src #(.DW(16), .DEPTH(4), .SEED(16'h0), .STEP(16'h1), .NSAMP(32)) dut_b (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .stream(b_if),
    .full(full_b), .samp_cnt(samp_b), .drop_cnt(drop_b), .done(done_b), .state(state_b)
  );
  valid_sample_src #(.DW(8), .DEPTH(4), .SEED(8'hFE), .STEP(8'h1), .NSAMP(3)) dut_c (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .stream(c_if),
    .full(full_c), .samp_cnt(samp_c), .drop_cnt(drop_c), .done(done_c), .state(state_c)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    int n;

    // T1: reset state, then a counted run of four samples with strobes every 5th cycle
    do_reset();
    check("rst_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_data", 32'(a_if.out_data), 32'd0);
    check("rst_full", 32'(full_a), 32'd0);
    check("rst_samp", 32'(samp_a), 32'd0);
    check("rst_drop", 32'(drop_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_state", 32'(state_a), 32'(S_IDLE));
    en = 1'b1;
    ready = 1'b1;
    step();
    check("t1_run", 32'(state_a), 32'(S_RUN));
    for (int k = 0; k < 4; k++) begin
      repeat (4) step();
      pulse();
      check("t1_valid", 32'(a_if.out_valid), 32'd1);
      check("t1_data", 32'(a_if.out_data), 32'(k));
    end
    n = 0;
    while (!done_a && n < 10) begin
      step();
      n++;
    end
    check("t1_done", 32'(done_a), 32'd1);
    check("t1_drop", 32'(drop_a), 32'd0);
    check("t1_samp", 32'(samp_a), 32'd4);
    en = 1'b0;
    step();
    check("t1_done_fall", 32'(done_a), 32'd0);
    check("t1_idle", 32'(state_a), 32'(S_IDLE));

    // T2: back-pressure, six strobes into four entries
    do_reset();
    en = 1'b1;
    ready = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      pulse();
      step();
      if (i == 3) check("t2_full4", 32'(full_b), 32'd1);
    end
    check("t2_drop", 32'(drop_b), 32'd2);
    check("t2_samp", 32'(samp_b), 32'd4);
    check("t2_full", 32'(full_b), 32'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
    ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("t2_valid", 32'(b_if.out_valid), 32'd1);
      check("t2_data", 32'(b_if.out_data), exp_q.pop_front());
      step();
    end
    check("t2_empty", 32'(b_if.out_valid), 32'd0);
    check("t2_hold", 32'(b_if.out_data), 32'd3);

    // T3: full FIFO with push and pop in the same cycle
    ready = 1'b0;
    repeat (4) begin
      pulse();
      step();
    end
    check("t3_full", 32'(full_b), 32'd1);
    in_valid = 1'b1;
    ready = 1'b1;
    step();
    in_valid = 1'b0;
    ready = 1'b0;
    check("t3_drop", 32'(drop_b), 32'd2);
    check("t3_samp", 32'(samp_b), 32'd9);
    check("t3_full_kept", 32'(full_b), 32'd1);
    for (int i = 5; i < 9; i++) exp_q.push_back(32'(i));
    ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("t3_data", 32'(b_if.out_data), exp_q.pop_front());
      step();
    end
    check("t3_empty", 32'(b_if.out_valid), 32'd0);

    // T5: reset with three entries queued mid-run
    ready = 1'b0;
    repeat (3) begin
      pulse();
      step();
    end
    check("t5_pre_data", 32'(b_if.out_data), 32'd9);
    check("t5_pre_samp", 32'(samp_b), 32'd12);
    do_reset();
    check("t5_valid", 32'(b_if.out_valid), 32'd0);
    check("t5_samp", 32'(samp_b), 32'd0);
    check("t5_drop", 32'(drop_b), 32'd0);
    check("t5_state", 32'(state_b), 32'(S_IDLE));
    check("t5_full", 32'(full_b), 32'd0);
    step();
    pulse();
    check("t5_seed_valid", 32'(b_if.out_valid), 32'd1);
    check("t5_seed_data", 32'(b_if.out_data), 32'd0);
    check("t5_seed_samp", 32'(samp_b), 32'd1);

    // T6: enable dropped with two entries queued
    do_reset();
    en = 1'b1;
    ready = 1'b0;
    step();
    pulse();
    step();
    pulse();
    step();
    check("t6_samp", 32'(samp_b), 32'd2);
    en = 1'b0;
    step();
    check("t6_drain", 32'(state_b), 32'(S_DRAIN));
    pulse();
    check("t6_ign_samp", 32'(samp_b), 32'd2);
    check("t6_ign_drop", 32'(drop_b), 32'd0);
    ready = 1'b1;
    check("t6_data0", 32'(b_if.out_data), 32'd0);
    step();
    check("t6_data1", 32'(b_if.out_data), 32'd1);
    n = 0;
    while (!done_b && n < 10) begin
      step();
      n++;
    end
    check("t6_done", 32'(done_b), 32'd1);
    step();
    check("t6_done_fall", 32'(done_b), 32'd0);
    check("t6_idle", 32'(state_b), 32'(S_IDLE));

    // T4: 8-bit ramp from FE wraps through zero
    do_reset();
    en = 1'b1;
    ready = 1'b0;
    step();
    repeat (3) begin
      pulse();
      step();
    end
    check("t4_state", 32'(state_c), 32'(S_DRAIN));
    check("t4_samp", 32'(samp_c), 32'd3);
    exp_q.push_back(32'h0FE);
    exp_q.push_back(32'h0FF);
    exp_q.push_back(32'h000);
    ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("t4_data", 32'(c_if.out_data), exp_q.pop_front());
      step();
    end
    n = 0;
    while (!done_c && n < 10) begin
      step();
      n++;
    end
    check("t4_done", 32'(done_c), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
